// File: rtl/mandelbrot_iter_ctrl_pkg.sv
// Shared definitions for the Mandelbrot iteration controller.
//   DATA_W    : width of one Q4.28 coordinate
//   FRAC_BITS : fractional bits of the Q4.28 format
//   ITER_W    : width of the iteration counter / limit
//   state_e   : controller FSM states
//   sat_data  : clamp a wide signed value into the DATA_W range
package mandelbrot_iter_ctrl_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 28;
    localparam int ITER_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Clamp to the representable range so an out-of-range result still reads
    // as a large magnitude rather than wrapping back towards the origin.
    function automatic logic [DATA_W-1:0] sat_data(input logic signed [63:0] v);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = 64'sh0000_0000_7FFF_FFFF;
        min_v = -64'sh0000_0000_8000_0000;
        if (v > max_v) begin
            sat_data = 32'h7FFF_FFFF;
        end else if (v < min_v) begin
            sat_data = 32'h8000_0000;
        end else begin
            sat_data = v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mandelbrot_func.sv
// Combinational Mandelbrot step: R = Z^2 + C, plus the escape test on Z.
// Ports:
//   zr, zi      : current Z, signed Q4.28
//   cr, ci      : point C, signed Q4.28
//   rr, ri      : next Z (saturated to the Q4.28 range)
//   unbounded   : 1 when |Z|^2 > 4.0 (strictly greater)
module mandelbrot_func
    import mandelbrot_iter_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] zr,
    input  logic [DATA_W-1:0] zi,
    input  logic [DATA_W-1:0] cr,
    input  logic [DATA_W-1:0] ci,
    output logic [DATA_W-1:0] rr,
    output logic [DATA_W-1:0] ri,
    output logic              unbounded
);

    // 4.0 expressed in the Q8.56 product format.
    localparam logic [64:0] FOUR_Q56 = 65'd4 << (2 * FRAC_BITS);

    logic signed [63:0] zr_x;
    logic signed [63:0] zi_x;
    logic signed [63:0] cr_x;
    logic signed [63:0] ci_x;
    logic signed [63:0] zr2;
    logic signed [63:0] zi2;
    logic signed [63:0] zri;
    logic        [64:0] mag2;
    logic signed [63:0] rr_wide;
    logic signed [63:0] ri_wide;

    assign zr_x = $signed({{32{zr[DATA_W-1]}}, zr});
    assign zi_x = $signed({{32{zi[DATA_W-1]}}, zi});
    assign cr_x = $signed({{32{cr[DATA_W-1]}}, cr});
    assign ci_x = $signed({{32{ci[DATA_W-1]}}, ci});

    // Squares are at most 2^62, so the 64-bit products never overflow.
    assign zr2 = zr_x * zr_x;
    assign zi2 = zi_x * zi_x;
    assign zri = zr_x * zi_x;

    // Both squares are non-negative; one extra bit holds their sum.
    assign mag2      = {1'b0, zr2} + {1'b0, zi2};
    assign unbounded = (mag2 > FOUR_Q56);

    // Back to Q4.28: drop FRAC_BITS fraction bits; 2*Zr*Zi drops one fewer.
    assign rr_wide = ((zr2 - zi2) >>> FRAC_BITS) + cr_x;
    assign ri_wide = (zri >>> (FRAC_BITS - 1)) + ci_x;

    assign rr = sat_data(rr_wide);
    assign ri = sat_data(ri_wide);

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// Mandelbrot iteration controller: accepts a point C, iterates Z <= Z^2 + C
// until escape or the iteration limit, then holds the result until consumed.
// Optional macro MANDELBROT_AUTO_STEP_EN: a job covers run_len points along
// the real axis, stepping Cr by cr_step after each consumed result.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : job handshake (accept on in_valid & in_ready)
//   in_cr, in_ci          : point C, signed Q4.28
//   max_iter              : iteration limit
//   out_valid / out_ready : result handshake
//   out_iter, out_escaped : iteration count, escape flag
//   busy                  : controller not idle
//   cr_step, run_len      : (macro only) Cr increment, points per job
//   fsm_state             : current FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on valid, and a pending result is held stable.
module mandelbrot_iter_ctrl
    import mandelbrot_iter_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_cr,
    input  logic [DATA_W-1:0] in_ci,
    input  logic [ITER_W-1:0] max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic              busy,
`ifdef MANDELBROT_AUTO_STEP_EN
    input  logic [DATA_W-1:0] cr_step,
    input  logic [ITER_W-1:0] run_len,
`endif
    output state_e            fsm_state
);

    state_e state;
    state_e state_next;

    logic [DATA_W-1:0] zr;
    logic [DATA_W-1:0] zi;
    logic [DATA_W-1:0] cr;
    logic [DATA_W-1:0] ci;
    logic [ITER_W-1:0] k;
    logic [ITER_W-1:0] lim;
    logic [ITER_W-1:0] res_iter;
    logic              res_esc;

    logic [DATA_W-1:0] rr;
    logic [DATA_W-1:0] ri;
    logic              unbounded;

    logic accept;
    logic step;
    logic finish;
    logic finish_esc;

`ifdef MANDELBROT_AUTO_STEP_EN
    logic [DATA_W-1:0] step_r;
    logic [ITER_W-1:0] remaining;
    logic              next_point;
`endif

    mandelbrot_func u_func (
        .zr        (zr),
        .zi        (zi),
        .cr        (cr),
        .ci        (ci),
        .rr        (rr),
        .ri        (ri),
        .unbounded (unbounded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        finish_esc = 1'b0;
`ifdef MANDELBROT_AUTO_STEP_EN
        next_point = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ITER;
                end
            end
            ST_ITER: begin
                // Escape is tested before the limit, so an escape exactly at
                // k == max_iter still reports as escaped.
                if (unbounded) begin
                    finish     = 1'b1;
                    finish_esc = 1'b1;
                    state_next = ST_DONE;
                end else if (k == lim) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
`ifdef MANDELBROT_AUTO_STEP_EN
                    if (remaining > 8'd1) begin
                        next_point = 1'b1;
                        state_next = ST_ITER;
                    end else begin
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr       <= '0;
            zi       <= '0;
            cr       <= '0;
            ci       <= '0;
            k        <= '0;
            lim      <= '0;
            res_iter <= '0;
            res_esc  <= 1'b0;
`ifdef MANDELBROT_AUTO_STEP_EN
            step_r    <= '0;
            remaining <= '0;
`endif
        end else begin
            if (accept) begin
                cr  <= in_cr;
                ci  <= in_ci;
                lim <= max_iter;
                zr  <= '0;
                zi  <= '0;
                k   <= '0;
`ifdef MANDELBROT_AUTO_STEP_EN
                step_r    <= cr_step;
                remaining <= (run_len == 8'd0) ? 8'd1 : run_len;
`endif
            end
            // k never passes lim, so this increment cannot wrap.
            if (step) begin
                zr <= rr;
                zi <= ri;
                k  <= k + 8'd1;
            end
            // On a limit finish k equals the latched max_iter.
            if (finish) begin
                res_iter <= k;
                res_esc  <= finish_esc;
            end
`ifdef MANDELBROT_AUTO_STEP_EN
            if (next_point) begin
                cr        <= cr + step_r;
                zr        <= '0;
                zi        <= '0;
                k         <= '0;
                remaining <= remaining - 8'd1;
            end
`endif
        end
    end

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);
    assign out_iter    = res_iter;
    assign out_escaped = res_esc;
    assign fsm_state   = state;

endmodule
